// File: rtl/keypad_pkg.sv
// Shared types, key constants and the key-map decode function
// for the 4x3 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_REL
    } state_t;

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    // Exactly one low column bit is a key; anything else decodes as KEY_NONE.
    function automatic logic [3:0] key_decode(
        input logic [1:0] row,
        input logic [2:0] col
    );
        logic [1:0] idx;
        logic       hit;
        logic [3:0] code;
        idx  = 2'd0;
        hit  = 1'b1;
        code = KEY_NONE;
        unique case (1'b1)
            (col == 3'b011): idx = 2'd0;
            (col == 3'b101): idx = 2'd1;
            (col == 3'b110): idx = 2'd2;
            default:         hit = 1'b0;
        endcase
        if (hit) begin
            if (row == 2'd3) begin
                unique case (idx)
                    2'd0:    code = KEY_STAR;
                    2'd1:    code = 4'h0;
                    default: code = KEY_HASH;
                endcase
            end else begin
                code = ({2'b00, row} * 4'd3) + {2'b00, idx} + 4'd1;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the scanner (master)
// and the keypad pins / application side (slave).
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [2:0] column;
    logic [2:0] sel;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  column,
        output sel,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output column,
        input  sel,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous column lines;
// resets to all-released (3'b111).
module keypad_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] d,
    output logic [2:0] q
);

    logic [2:0] meta;

    // Double-register the raw columns into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 3'b111;
            q    <= 3'b111;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning, debouncing front end for a 4x3 matrix keypad.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE_CNT  = 20000,
    parameter int REPEAT_DLY    = 5_000_000,
    parameter int REPEAT_PERIOD = 1_000_000
) (
    input logic             clk,
    input logic             rst_n,
    keypad_scanner_if.master kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX =
        (REPEAT_DLY > REPEAT_PERIOD) ? REPEAT_DLY : REPEAT_PERIOD;
    localparam int REP_W = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
    localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DLY - 1);
    localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PERIOD - 1);
    logic [REP_W-1:0] rep_cnt;
    logic             rep_first;
`endif

    state_t           state;
    logic [1:0]       sel_q;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;
    logic [2:0]       cap_col;
    logic [3:0]       code_q;
    logic             valid_q;
    logic             held_q;
    logic [2:0]       col_s;

    keypad_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (kp.column),
        .q     (col_s)
    );

    assign kp.sel       = {1'b0, sel_q};
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;

    // Scan / debounce state machine with registered key outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCAN;
            sel_q   <= 2'd0;
            div_cnt <= '0;
            deb_cnt <= '0;
            cap_col <= 3'b111;
            code_q  <= KEY_NONE;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (key_decode(sel_q, col_s) != KEY_NONE) begin
                            cap_col <= col_s;
                            deb_cnt <= '0;
                            state   <= DEB_PRESS;
                        end else begin
                            sel_q <= sel_q + 2'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (col_s != cap_col) begin
                        state <= SCAN;
                        sel_q <= sel_q + 2'd1;
                    end else if (deb_cnt == DEB_LAST) begin
                        code_q  <= key_decode(sel_q, cap_col);
                        valid_q <= 1'b1;
                        held_q  <= 1'b1;
                        state   <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt   <= '0;
                        rep_first <= 1'b1;
`endif
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (col_s == 3'b111) begin
                        deb_cnt <= '0;
                        state   <= DEB_REL;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rep_cnt == (rep_first ? DLY_LAST : PER_LAST)) begin
                        valid_q   <= 1'b1;
                        rep_cnt   <= '0;
                        rep_first <= 1'b0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
`endif
                end
                DEB_REL: begin
                    if (col_s != 3'b111) begin
                        state <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        held_q  <= 1'b0;
                        deb_cnt <= '0;
                        sel_q   <= sel_q + 2'd1;
                        state   <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
